instr_fetch_ctrl: RTL and testbench

- Sequences the synchronous instruction ROM (comROM: 256 x 32, registered address, 1-cycle read latency, clken-gated) for the single-cycle CPU.
- Owns the fetch PC and drives ROM address/clken.
- Presents fetched words to decode via a valid/ready handshake.
- Handles start, stall (backpressure), branch/jump redirect and halt.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/instr_fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle-latency synchronous instruction ROM; owns the PC
// and hands fetched words to decode over a valid/ready handshake.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_clken,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              running
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              issue_s;
  logic [ADDR_W-1:0] issue_addr_s;
  logic              advance_s;

  assign advance_s = !instr_valid_q || instr_ready;

  // Next-state: decide whether a ROM read is issued this cycle and at which address.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    issue_s       = 1'b0;
    issue_addr_s  = fetch_pc_q;
    case (state_q)
      ST_IDLE: begin
        instr_valid_d = 1'b0;
        if (start) begin
          issue_s      = 1'b1;
          issue_addr_s = RESET_PC;
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (redirect_valid) begin
          issue_s      = 1'b1;
          issue_addr_s = redirect_pc;
        end else if (halt) begin
          state_d       = ST_HALTED;
          instr_valid_d = 1'b0;
        end else if (advance_s) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_HALTED: begin
        instr_valid_d = 1'b0;
        if (redirect_valid) begin
          issue_s      = 1'b1;
          issue_addr_s = redirect_pc;
        end else begin
          issue_s = 1'b0;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        instr_valid_d = 1'b0;
      end
    endcase
    if (issue_s) begin
      state_d       = ST_RUN;
      instr_pc_d    = issue_addr_s;
      fetch_pc_d    = issue_addr_s + PC_ONE;
      instr_valid_d = 1'b1;
    end else begin
      instr_valid_d = instr_valid_d;
    end
  end

  // ROM port: clock enable is suppressed while reset is asserted.
  always_comb begin
    rom_clken = 1'b0;
    rom_addr  = fetch_pc_q;
    if (reset_n && issue_s) begin
      rom_clken = 1'b1;
      rom_addr  = issue_addr_s;
    end else begin
      rom_clken = 1'b0;
      rom_addr  = fetch_pc_q;
    end
  end

  // State and PC registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign instr       = rom_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a ROM preloaded word[i]=i and a
// stream-level reference model checked every cycle.
module tb_instr_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset_n, start, instr_ready, redirect_valid, halt;
  logic [7:0]  redirect_pc;
  logic [7:0]  rom_addr, instr_pc;
  logic        rom_clken, instr_valid, running;
  logic [31:0] rom_q, instr;
  logic [31:0] rom [256];

  int checks = 0;
  int errors = 0;

  instr_fetch_ctrl dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .rom_addr(rom_addr), .rom_clken(rom_clken), .rom_q(rom_q),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .running(running)
  );

  always #5 clock = ~clock;

  // comROM stand-in: registered read, enable-gated
  initial for (int i = 0; i < 256; i++) rom[i] = 32'(i);
  initial rom_q = 32'd0;
  always @(posedge clock) if (rom_clken) rom_q <= rom[rom_addr];

  // Reference model: mode 0 idle, 1 run, 2 halted; the presented word and the next sequential PC
  int         m_mode  = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_pc    = 8'd0;
  logic [7:0] m_next  = 8'd0;

  function automatic void predict(output bit issue, output logic [7:0] a);
    issue = 1'b0;
    a = m_next;
    if (!reset_n) return;
    if (m_mode == 0 && start) begin
      issue = 1'b1; a = 8'd0;
    end else if (m_mode != 0 && redirect_valid) begin
      issue = 1'b1; a = redirect_pc;
    end else if (m_mode == 1 && !halt && (!m_valid || instr_ready)) begin
      issue = 1'b1;
    end
  endfunction

  always @(posedge clock) begin
    bit iss;
    logic [7:0] a;
    predict(iss, a);
    if (!reset_n) begin
      m_mode = 0; m_valid = 1'b0; m_pc = 8'd0; m_next = 8'd0;
    end else if (iss) begin
      m_mode = 1; m_valid = 1'b1; m_pc = a; m_next = a + 8'd1;
    end else if (m_mode == 1 && halt) begin
      m_mode = 2; m_valid = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  initial begin
    @(posedge clock);
    forever begin
      bit iss;
      logic [7:0] a;
      @(negedge clock);
      predict(iss, a);
      chk("m_clken", {31'd0, rom_clken}, {31'd0, iss});
      chk("m_addr", {24'd0, rom_addr}, {24'd0, a});
      chk("m_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("m_running", {31'd0, running}, {31'd0, m_mode == 1});
      chk("m_pc", {24'd0, instr_pc}, {24'd0, m_pc});
      if (m_valid) chk("m_instr", instr, {24'd0, m_pc});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic redirect_to(input logic [7:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 8'd0; halt = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_clken", {31'd0, rom_clken}, 32'd0);
    reset_n = 1'b1;
    tick();

    // start and sequential stream 0..9
    start = 1'b1; #1;
    chk("start_clken", {31'd0, rom_clken}, 32'd1);
    chk("start_addr", {24'd0, rom_addr}, 32'd0);
    tick(); start = 1'b0;
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_pc", {24'd0, instr_pc}, 32'd0);
    chk("first_instr", instr, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("seq_pc", {24'd0, instr_pc}, 32'(k));
    end

    // stall at pc 3
    redirect_to(8'd3);
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("stall_clken", {31'd0, rom_clken}, 32'd0);
      tick();
      chk("stall_pc", {24'd0, instr_pc}, 32'd3);
      chk("stall_instr", instr, 32'd3);
    end
    instr_ready = 1'b1;
    tick();
    chk("unstall_pc", {24'd0, instr_pc}, 32'd4);
    tick();
    chk("pc5", {24'd0, instr_pc}, 32'd5);

    // redirect discards an unaccepted word
    instr_ready = 1'b0;
    redirect_to(8'h40);
    instr_ready = 1'b1;
    chk("redir_pc", {24'd0, instr_pc}, 32'h40);
    tick(); chk("redir_pc1", {24'd0, instr_pc}, 32'h41);
    tick(); chk("redir_pc2", {24'd0, instr_pc}, 32'h42);

    // wrap 0xFE -> 0x01
    redirect_to(8'hFE);
    chk("wrap_fe", {24'd0, instr_pc}, 32'hFE);
    tick(); chk("wrap_ff", {24'd0, instr_pc}, 32'hFF);
    tick(); chk("wrap_00", {24'd0, instr_pc}, 32'h00);
    tick(); chk("wrap_01", {24'd0, instr_pc}, 32'h01);

    // halt at pc 7, start ignored, redirect resumes
    redirect_to(8'd7);
    halt = 1'b1; #1;
    chk("halt_clken", {31'd0, rom_clken}, 32'd0);
    tick(); halt = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("halted_valid", {31'd0, instr_valid}, 32'd0);
      chk("halted_running", {31'd0, running}, 32'd0);
      chk("halted_clken", {31'd0, rom_clken}, 32'd0);
      tick();
      start = 1'b0;
    end
    redirect_valid = 1'b1; redirect_pc = 8'h10; #1;
    chk("resume_addr", {24'd0, rom_addr}, 32'h10);
    tick(); redirect_valid = 1'b0;
    chk("resume_pc", {24'd0, instr_pc}, 32'h10);
    chk("resume_running", {31'd0, running}, 32'd1);

    // redirect with halt: redirect wins; then ready toggling
    halt = 1'b1;
    redirect_to(8'h30);
    halt = 1'b0;
    chk("redir_halt_pc", {24'd0, instr_pc}, 32'h30);
    for (int k = 0; k < 12; k++) begin
      instr_ready = (k % 3) != 1;
      tick();
    end
    instr_ready = 1'b1;

    // reset mid-stream
    redirect_to(8'h22);
    chk("pre_rst_pc", {24'd0, instr_pc}, 32'h22);
    reset_n = 1'b0; #1;
    chk("rst_mid_clken", {31'd0, rom_clken}, 32'd0);
    tick(); reset_n = 1'b1;
    chk("rst_mid_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_mid_running", {31'd0, running}, 32'd0);
    redirect_to(8'h50);
    chk("idle_redir_ignored", {31'd0, instr_valid}, 32'd0);
    start = 1'b1; #1;
    chk("restart_addr", {24'd0, rom_addr}, 32'd0);
    tick(); start = 1'b0;
    chk("restart_pc", {24'd0, instr_pc}, 32'd0);
    tick(); chk("restart_pc1", {24'd0, instr_pc}, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
